window_buffer_7x7_ctrl: RTL and testbench
=========================================

# window_buffer_7x7_ctrl

Controller FSM that sequences the 7x7 window buffer datapath over one frame. It gates the datapath column counter (`count_en`) from upstream line-buffer validity and tracks fill, active and row-end phases from the datapath status flags. It emits a window-valid strobe aligned to the datapath's 2-stage window pipeline and a frame-done pulse with a window-count check. It sits between the line buffers and the downstream 7x7 filter kernel (median/Gaussian).

## Interface
- `COLS`, 9: frame width in pixels.
- `ROWS`, 9: frame height in pixels.
- `EXP_WIN`, `(COLS-6)*(ROWS-6)`: expected valid windows per frame.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous active-low reset.
- `start_i` input 1: 1-cycle frame-start pulse.
- `valid_i` input 1: line buffers present a valid 7-pixel column this cycle.
- `i_col_ge_threshold` input 1: datapath flag, window holds enough columns.
- `i_col_eq_max` input 1: datapath flag, last column of the current row pass.
- `i_row_eq_max` input 1: datapath flag, last row pass of the frame.
- `count_en` output 1: datapath counter enable.
- `valid_o` output 1: the S1..S49 window is valid this cycle.
- `busy_o` output 1: a frame is in progress.
- `done_o` output 1: 1-cycle end-of-frame pulse.
- `err_o` output 1: window-count mismatch. Valid with `done_o` and held until the next `start_i`.
- `win_cnt_o` output 16: valid windows emitted in the current or last frame.

## Operation
- **States:** IDLE, FILL, ACTIVE, DRAIN, DONE.
- **IDLE:**
  - `count_en`=0.
  - On `start_i`: go to FILL, clear `win_cnt_o` and `err_o`.
  - `valid_i` alone is ignored.
- **FILL:**
  - `count_en` = `valid_i`.
  - When `valid_i` & `i_col_ge_threshold`: go to ACTIVE.
- **ACTIVE:**
  - `count_en` = `valid_i`.
  - The window-valid source `wv` = `valid_i`.
  - When `valid_i` & `i_col_eq_max`: go to DRAIN if `i_row_eq_max`, else to FILL (the next row pass refills).
- **DRAIN:**
  - `count_en`=0.
  - Waits exactly 2 cycles (2-bit counter) so the delayed `valid_o` pipeline empties, then goes to DONE.
- **DONE:**
  - `done_o`=1 for one cycle.
  - `err_o` <= (`win_cnt_o` != `EXP_WIN`).
  - Next state: IDLE.
- **Stall:** when `valid_i`=0 in FILL or ACTIVE, `count_en`=0, `wv`=0 and the state holds. A stall of any length is legal.
- **`start_i` while busy:** ignored; no restart and no error.
- **Window counter:** `win_cnt_o` += 1 on each `valid_o`. It saturates at 16'hFFFF; it never wraps.
- **`busy_o`:** 1 in FILL, ACTIVE and DRAIN. `done_o` fires only in DONE.
- **Simultaneous flags:** when `i_col_eq_max` and `i_col_ge_threshold` are both high in FILL, `i_col_ge_threshold` has priority (go to ACTIVE). `i_col_eq_max` is acted on only in ACTIVE.

## Timing
- **`count_en`:** combinational from the state and `valid_i`; same cycle as the column.
- **`valid_o`:** `wv` delayed by 2 registers, matching the datapath input-delay stage plus the window shift stage.
- **`done_o` and `err_o`:** registered. `done_o` rises at least 1 cycle after the last `valid_o`.
- **Reset values:** all outputs 0; state IDLE; delay pipeline cleared.
- **Reset mid-frame:** the next cycle is IDLE with all outputs 0. The in-flight `wv` bits are discarded, so no `valid_o` follows.

## Structure
- **Shared package `window_buffer_pkg`:**
  - State enum: IDLE=0, FILL=1, ACTIVE=2, DRAIN=3, DONE=4, 3-bit.
  - `WIN_PIPE_LAT`=2.
  - Window-count width 16.
- **Sub-module `valid_delay`:** a parameterized-depth shift register with synchronous reset, used for the `wv`→`valid_o` alignment. The rest is the FSM, the drain counter and the window counter.

## Test plan
- **Reset behaviour:** hold `rst_n`=0 for 3 cycles with `valid_i`=1 → all outputs 0, `count_en`=0, no `valid_o` after release until `start_i`.
- **Nominal frame:** COLS=ROWS=9, `start_i`, continuous `valid_i`, flags driven by the real datapath → exactly 9 `valid_o` pulses, `done_o` once, `err_o`=0, `win_cnt_o`=9.
- **Stall:** drop `valid_i` for 5 cycles mid-ACTIVE → `count_en`=0 and the `valid_o` gap is exactly 5 cycles, 2 cycles later. The frame still yields 9 windows and `err_o`=0.
- **Count mismatch:** force `i_row_eq_max` early (after the 1st row pass) → `done_o` with `err_o`=1 and `win_cnt_o`=3.
- **`start_i` while busy:** pulse `start_i` in ACTIVE → no effect, and `win_cnt_o` is not cleared. A pulse in IDLE after `done_o` restarts the frame and clears `err_o`.
- **Mid-frame reset:** assert `rst_n`=0 for 1 cycle in ACTIVE → the next cycle is IDLE, `valid_o` never rises afterward, and there is no `done_o`.

Source files
------------

// File: rtl/window_buffer_7x7_ctrl_pkg.sv
// Shared types and constants for the 7x7 window buffer controller.
package window_buffer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_ACTIVE = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    localparam int WIN_PIPE_LAT = 2;
    localparam int WIN_CNT_W    = 16;

    function automatic logic [WIN_CNT_W-1:0] sat_inc(
        input logic [WIN_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/window_buffer_7x7_ctrl_if.sv
// Control/status bundle between line buffers, datapath and controller.
interface window_buffer_7x7_ctrl_if;
    import window_buffer_pkg::*;

    logic                 start_i;
    logic                 valid_i;
    logic                 i_col_ge_threshold;
    logic                 i_col_eq_max;
    logic                 i_row_eq_max;
    logic                 count_en;
    logic                 valid_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;
    logic [WIN_CNT_W-1:0] win_cnt_o;

    modport master (
        output start_i, valid_i,
        output i_col_ge_threshold, i_col_eq_max, i_row_eq_max,
        input  count_en, valid_o, busy_o, done_o, err_o, win_cnt_o
    );

    modport slave (
        input  start_i, valid_i,
        input  i_col_ge_threshold, i_col_eq_max, i_row_eq_max,
        output count_en, valid_o, busy_o, done_o, err_o, win_cnt_o
    );

endinterface

// File: rtl/window_buffer_7x7_ctrl_valid_delay.sv
// Fixed-depth single-bit delay line with synchronous reset.
module valid_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = DEPTH'({sr_q, d_i});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= sr_d;
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/window_buffer_7x7_ctrl.sv
// Frame sequencer for the 7x7 window datapath: counter gating,
// window-valid alignment, and end-of-frame window-count check.
module window_buffer_7x7_ctrl
    import window_buffer_pkg::*;
#(
    parameter int COLS    = 9,
    parameter int ROWS    = 9,
    parameter int EXP_WIN = (COLS-6)*(ROWS-6)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    window_buffer_7x7_ctrl_if.slave  bus
);

    state_e               state_q, state_d;
    logic [1:0]           drain_q, drain_d;
    logic [WIN_CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic                 count_en_w;
    logic                 wv;
    logic                 valid_dly;

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        err_d      = err_q;
        done_d     = 1'b0;
        count_en_w = 1'b0;
        wv         = 1'b0;
        win_cnt_d  = valid_dly ? sat_inc(win_cnt_q) : win_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d   = S_FILL;
                    win_cnt_d = '0;
                    err_d     = 1'b0;
                end
            end
            S_FILL: begin
                count_en_w = bus.valid_i;
                if (bus.valid_i && bus.i_col_ge_threshold)
                    state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                count_en_w = bus.valid_i;
                wv         = bus.valid_i;
                drain_d    = '0;
                if (bus.valid_i && bus.i_col_eq_max)
                    state_d = bus.i_row_eq_max ? S_DRAIN : S_FILL;
            end
            S_DRAIN: begin
                drain_d = drain_q + 2'd1;
                // last window lands on the same edge we leave DRAIN,
                // so the check must use the post-increment count
                if (drain_q == 2'(WIN_PIPE_LAT-1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = (win_cnt_d != WIN_CNT_W'(EXP_WIN));
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            drain_q   <= '0;
            win_cnt_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            win_cnt_q <= win_cnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    valid_delay #(
        .DEPTH (WIN_PIPE_LAT)
    ) u_valid_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (wv),
        .q_o   (valid_dly)
    );

    assign bus.count_en  = count_en_w;
    assign bus.valid_o   = valid_dly;
    assign bus.busy_o    = (state_q == S_FILL) ||
                           (state_q == S_ACTIVE) ||
                           (state_q == S_DRAIN);
    assign bus.done_o    = done_q;
    assign bus.err_o     = err_q;
    assign bus.win_cnt_o = win_cnt_q;

endmodule

// File: tb/tb_window_buffer_7x7_ctrl.sv
// Directed bench for window_buffer_7x7_ctrl with a behavioural column/row datapath.
module tb_window_buffer_7x7_ctrl;

    localparam int COLS = 9;
    localparam int ROWS = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    window_buffer_7x7_ctrl_if bus();

    window_buffer_7x7_ctrl #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int col = 0;
    int row = 0;
    bit force_re = 1'b0;

    int vo_n;
    int vo_t [64];
    int done_n;
    int done_cyc;
    logic done_err;
    logic [15:0] done_cnt;
    logic st_err, st_busy;
    logic [15:0] st_cnt;
    logic bs_busy;
    logic [15:0] bs_cnt;

    // datapath stand-in: 7 columns fill the window, flag set once 6 are in
    assign bus.i_col_ge_threshold = (col >= 5);
    assign bus.i_col_eq_max       = (col == COLS-1);
    assign bus.i_row_eq_max       = force_re || (row == ROWS-7);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n || (bus.start_i && !bus.busy_o)) begin
            col <= 0;
            row <= 0;
        end else if (bus.count_en) begin
            if (col == COLS-1) begin
                col <= 0;
                row <= row + 1;
            end else begin
                col <= col + 1;
            end
        end
    end

    task automatic run_frame(input int stall_len, input bit busy_start);
        bit trig;
        int left;
        int post;
        bit pend;
        vo_n = 0;
        done_n = 0;
        trig = 1'b0;
        left = 0;
        post = 0;
        pend = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.valid_i = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.valid_i = 1'b1;
        st_err  = bus.err_o;
        st_busy = bus.busy_o;
        st_cnt  = bus.win_cnt_o;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            if (pend) begin
                pend = 1'b0;
                bs_busy = bus.busy_o;
                bs_cnt  = bus.win_cnt_o;
            end
            if (bus.valid_o) begin
                if (vo_n < 64) vo_t[vo_n] = cyc;
                vo_n++;
            end
            if (bus.done_o) begin
                done_n++;
                done_cyc = cyc;
                done_err = bus.err_o;
                done_cnt = bus.win_cnt_o;
            end
            if (done_n > 0) begin
                bus.valid_i = 1'b0;
                post++;
                if (post > 3) break;
                continue;
            end
            if (!trig && row == 1 && col == 7) begin
                trig = 1'b1;
                if (busy_start) begin
                    bus.start_i = 1'b1;
                    pend = 1'b1;
                end
                left = stall_len;
            end
            if (left > 0) begin
                left--;
                bus.valid_i = 1'b0;
                #1;
                checks++;
                if (bus.count_en !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_count_en: got %b expected 0", bus.count_en);
                end
            end else begin
                bus.valid_i = 1'b1;
            end
        end
        checks++;
        if (done_n == 0) begin
            errors++;
            $display("FAIL frame_timeout: got no done_o expected done_o within 400 cycles");
        end
    endtask

    task automatic test_reset();
        logic [20:0] obs;
        rst_n = 1'b0;
        bus.valid_i = 1'b1;
        bus.start_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            obs = {bus.count_en, bus.valid_o, bus.busy_o,
                   bus.done_o, bus.err_o, bus.win_cnt_o};
            checks++;
            if (obs !== 21'd0) begin
                errors++;
                $display("FAIL reset_outputs: got %h expected 0", obs);
            end
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            obs = {bus.count_en, bus.valid_o, bus.busy_o,
                   bus.done_o, bus.err_o, bus.win_cnt_o};
            checks++;
            if (obs !== 21'd0) begin
                errors++;
                $display("FAIL post_reset_idle: got %h expected 0", obs);
            end
        end
        bus.valid_i = 1'b0;
    endtask

    task automatic test_nominal();
        run_frame(0, 1'b0);
        checks++;
        if (vo_n !== 9) begin
            errors++;
            $display("FAIL nominal_windows: got %0d expected 9", vo_n);
        end
        checks++;
        if (done_n !== 1) begin
            errors++;
            $display("FAIL nominal_done_count: got %0d expected 1", done_n);
        end
        checks++;
        if (done_err !== 1'b0) begin
            errors++;
            $display("FAIL nominal_err: got %b expected 0", done_err);
        end
        checks++;
        if (done_cnt !== 16'd9) begin
            errors++;
            $display("FAIL nominal_win_cnt: got %0d expected 9", done_cnt);
        end
        checks++;
        if (vo_t[1] - vo_t[0] !== 1) begin
            errors++;
            $display("FAIL nominal_spacing: got %0d expected 1", vo_t[1] - vo_t[0]);
        end
        checks++;
        if (vo_t[3] - vo_t[2] !== 7) begin
            errors++;
            $display("FAIL nominal_refill_gap: got %0d expected 7", vo_t[3] - vo_t[2]);
        end
        checks++;
        if (done_cyc - vo_t[8] !== 1) begin
            errors++;
            $display("FAIL nominal_done_lag: got %0d expected 1", done_cyc - vo_t[8]);
        end
    endtask

    task automatic test_stall();
        run_frame(5, 1'b0);
        checks++;
        if (vo_n !== 9) begin
            errors++;
            $display("FAIL stall_windows: got %0d expected 9", vo_n);
        end
        checks++;
        if (vo_t[4] - vo_t[3] !== 6) begin
            errors++;
            $display("FAIL stall_gap: got %0d expected 6", vo_t[4] - vo_t[3]);
        end
        checks++;
        if (vo_t[5] - vo_t[4] !== 1) begin
            errors++;
            $display("FAIL stall_resume: got %0d expected 1", vo_t[5] - vo_t[4]);
        end
        checks++;
        if (done_err !== 1'b0 || done_cnt !== 16'd9) begin
            errors++;
            $display("FAIL stall_result: got err=%b cnt=%0d expected err=0 cnt=9",
                     done_err, done_cnt);
        end
    endtask

    task automatic test_mismatch();
        force_re = 1'b1;
        run_frame(0, 1'b0);
        force_re = 1'b0;
        checks++;
        if (vo_n !== 3) begin
            errors++;
            $display("FAIL mismatch_windows: got %0d expected 3", vo_n);
        end
        checks++;
        if (done_err !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_err: got %b expected 1", done_err);
        end
        checks++;
        if (done_cnt !== 16'd3) begin
            errors++;
            $display("FAIL mismatch_win_cnt: got %0d expected 3", done_cnt);
        end
        checks++;
        if (bus.err_o !== 1'b1 || bus.win_cnt_o !== 16'd3) begin
            errors++;
            $display("FAIL mismatch_hold: got err=%b cnt=%0d expected err=1 cnt=3",
                     bus.err_o, bus.win_cnt_o);
        end
    endtask

    task automatic test_restart();
        run_frame(0, 1'b0);
        checks++;
        if (st_err !== 1'b0) begin
            errors++;
            $display("FAIL restart_err_clear: got %b expected 0", st_err);
        end
        checks++;
        if (st_cnt !== 16'd0) begin
            errors++;
            $display("FAIL restart_cnt_clear: got %0d expected 0", st_cnt);
        end
        checks++;
        if (st_busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_busy: got %b expected 1", st_busy);
        end
        checks++;
        if (done_err !== 1'b0 || done_cnt !== 16'd9) begin
            errors++;
            $display("FAIL restart_result: got err=%b cnt=%0d expected err=0 cnt=9",
                     done_err, done_cnt);
        end
    endtask

    task automatic test_start_while_busy();
        run_frame(0, 1'b1);
        checks++;
        if (bs_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_busy: got %b expected 1", bs_busy);
        end
        checks++;
        if (bs_cnt !== 16'd3) begin
            errors++;
            $display("FAIL busy_start_cnt: got %0d expected 3", bs_cnt);
        end
        checks++;
        if (vo_n !== 9 || done_n !== 1) begin
            errors++;
            $display("FAIL busy_start_frame: got win=%0d done=%0d expected win=9 done=1",
                     vo_n, done_n);
        end
        checks++;
        if (done_err !== 1'b0 || done_cnt !== 16'd9) begin
            errors++;
            $display("FAIL busy_start_result: got err=%b cnt=%0d expected err=0 cnt=9",
                     done_err, done_cnt);
        end
    endtask

    task automatic test_midframe_reset();
        logic [20:0] obs;
        bit hit;
        int vo_seen;
        int dn_seen;
        hit = 1'b0;
        vo_seen = 0;
        dn_seen = 0;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.valid_i = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.valid_i = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (row == 0 && col == 7) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midreset_reach_active: got timeout expected col 7");
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        obs = {bus.count_en, bus.valid_o, bus.busy_o,
               bus.done_o, bus.err_o, bus.win_cnt_o};
        checks++;
        if (obs !== 21'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h expected 0", obs);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.valid_o) vo_seen++;
            if (bus.done_o) dn_seen++;
        end
        checks++;
        if (vo_seen !== 0) begin
            errors++;
            $display("FAIL midreset_no_valid: got %0d expected 0", vo_seen);
        end
        checks++;
        if (dn_seen !== 0) begin
            errors++;
            $display("FAIL midreset_no_done: got %0d expected 0", dn_seen);
        end
        bus.valid_i = 1'b0;
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.valid_i = 1'b0;
        test_reset();
        test_nominal();
        test_stall();
        test_mismatch();
        test_restart();
        test_start_while_busy();
        test_midframe_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
